// File: rtl/pwm_compare_dt_if.sv
// Bus between the counter/register stage and pwm_compare_dt: configuration, counter value and the PWM outputs.
interface pwm_compare_dt_if #(
  parameter int WIDTH    = 64,
  parameter int DT_WIDTH = 8
);
  logic                PWM_EN;
  logic                mode;
  logic [WIDTH-1:0]    AAR;
  logic [WIDTH-1:0]    cnt_val;
  logic [WIDTH-1:0]    CCR_in;
  logic                CCR_wr;
  logic [DT_WIDTH-1:0] DTR;
  logic                POL;
  logic                pwm_h;
  logic                pwm_l;
  logic                update_evt;
  logic [WIDTH-1:0]    ccr_active;

  modport master (
    output PWM_EN, mode, AAR, cnt_val, CCR_in, CCR_wr, DTR, POL,
    input  pwm_h, pwm_l, update_evt, ccr_active
  );

  modport slave (
    input  PWM_EN, mode, AAR, cnt_val, CCR_in, CCR_wr, DTR, POL,
    output pwm_h, pwm_l, update_evt, ccr_active
  );
endinterface

// File: rtl/pwm_compare_dt.sv
// Preloaded compare channel with complementary outputs; dead-time states exist only with PWM_DEADTIME_EN defined.
// Outputs change two edges after the counter edge (plus DTR cycles entering an ON state); no backpressure.
module pwm_compare_dt #(
  parameter int WIDTH    = 64,
  parameter int DT_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  pwm_compare_dt_if.slave bus
);

`ifdef PWM_DEADTIME_EN
  typedef enum logic [2:0] {IDLE, H_ON, L_ON, DT_L2H, DT_H2L} state_t;
`else
  typedef enum logic [1:0] {IDLE, H_ON, L_ON} state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] ccr_pre;
  logic [WIDTH-1:0] ccr_act;
  logic             upd_cond;
  logic             evt_q;
  logic             ref_q;
  logic             h_q;
  logic             l_q;

`ifdef PWM_DEADTIME_EN
  logic [DT_WIDTH-1:0] dt_cnt;
  logic [DT_WIDTH-1:0] dt_nxt;
`else
  logic unused_dtr;
  assign unused_dtr = ^bus.DTR;
`endif

  assign upd_cond = bus.mode ? (bus.cnt_val == '0) : (bus.cnt_val >= bus.AAR);

  // A write coinciding with an update still hands the old preload to ccr_act.
  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_pre <= '0;
      ccr_act <= '0;
      evt_q   <= 1'b0;
      ref_q   <= 1'b0;
    end else begin
      if (bus.CCR_wr) begin
        ccr_pre <= bus.CCR_in;
      end
      if (!bus.PWM_EN || upd_cond) begin
        ccr_act <= ccr_pre;
      end
      evt_q <= bus.PWM_EN && upd_cond;
      ref_q <= (bus.cnt_val < ccr_act);
    end
  end

  always_comb begin
    state_nxt = state;
`ifdef PWM_DEADTIME_EN
    dt_nxt    = dt_cnt;
`endif
    if (!bus.PWM_EN) begin
      state_nxt = IDLE;
`ifdef PWM_DEADTIME_EN
      dt_nxt    = '0;
`endif
    end else begin
      case (state)
        IDLE: state_nxt = L_ON;
`ifdef PWM_DEADTIME_EN
        L_ON: begin
          if (ref_q) begin
            if (bus.DTR == '0) begin
              state_nxt = H_ON;
            end else begin
              state_nxt = DT_L2H;
              dt_nxt    = bus.DTR;
            end
          end
        end
        H_ON: begin
          if (!ref_q) begin
            if (bus.DTR == '0) begin
              state_nxt = L_ON;
            end else begin
              state_nxt = DT_H2L;
              dt_nxt    = bus.DTR;
            end
          end
        end
        // A reference reversal inside the gap restarts it toward the other side,
        // so reference pulses shorter than the dead time never reach a pin.
        DT_L2H: begin
          if (!ref_q) begin
            state_nxt = DT_H2L;
            dt_nxt    = bus.DTR;
          end else if (dt_cnt <= DT_WIDTH'(1)) begin
            state_nxt = H_ON;
            dt_nxt    = '0;
          end else begin
            dt_nxt = dt_cnt - DT_WIDTH'(1);
          end
        end
        DT_H2L: begin
          if (ref_q) begin
            state_nxt = DT_L2H;
            dt_nxt    = bus.DTR;
          end else if (dt_cnt <= DT_WIDTH'(1)) begin
            state_nxt = L_ON;
            dt_nxt    = '0;
          end else begin
            dt_nxt = dt_cnt - DT_WIDTH'(1);
          end
        end
`else
        L_ON: if (ref_q)  state_nxt = H_ON;
        H_ON: if (!ref_q) state_nxt = L_ON;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      h_q   <= bus.POL;
      l_q   <= bus.POL;
`ifdef PWM_DEADTIME_EN
      dt_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      h_q   <= (state_nxt == H_ON) ^ bus.POL;
      l_q   <= (state_nxt == L_ON) ^ bus.POL;
`ifdef PWM_DEADTIME_EN
      dt_cnt <= dt_nxt;
`endif
    end
  end

  assign bus.pwm_h      = h_q;
  assign bus.pwm_l      = l_q;
  assign bus.update_evt = evt_q;
  assign bus.ccr_active = ccr_act;

endmodule
